// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if -- control bundle between the multi-cycle controller and the
// shared MIPS datapath.
//
// Signals:
//   op, funct, zero     datapath -> controller (IR fields and ALU equality)
//   ir_write, pc_write  controller -> datapath register enables
//   pc_src, reg_dst,
//   wd_src, alu_src,
//   alu_op, ext_op      controller -> datapath mux/ALU selects
//   mem_write           controller -> data memory write enable
//   state               current controller state (observability)
//   instr_done          pulse on the last cycle of each legal instruction
//   illegal             pulse when an undecodable instruction is dropped
//   retired             count of retired legal instructions (CNT_W bits)
//
// Modports:
//   master  the controller side (drives enables/selects)
//   slave   the datapath side (drives op/funct/zero)
//
// CNT_W must match the CNT_W of the mc_ctrl instance attached to it.
// -----------------------------------------------------------------------------
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;

    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_src;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             ext_op;
    logic             mem_write;
    logic [2:0]       state;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero,
        output ir_write, pc_write, pc_src, reg_write, reg_dst, wd_src,
               alu_src, alu_op, ext_op, mem_write, state, instr_done,
               illegal, retired
    );

    modport slave (
        output op, funct, zero,
        input  ir_write, pc_write, pc_src, reg_write, reg_dst, wd_src,
               alu_src, alu_op, ext_op, mem_write, state, instr_done,
               illegal, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for the MIPS core.
//
// Sequences one shared datapath (single memory port, single ALU, register
// file, IR, PC) through FETCH -> DECODE -> EXE -> MEM -> WB, taking 2..5
// states per instruction. All enables and selects are combinational from
// the current state, op, funct and zero; the only state is the FSM register,
// the fetch-latency counter and the retired-instruction counter.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter
//   FETCH_CYC  cycles spent in FETCH (memory latency), legal range 1..4
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    mc_ctrl_if.master (IR fields in, enables/selects/status out)
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FETCH_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);

    // -------------------------------------------------------------------------
    // Types
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        K_ADDU,
        K_SUBU,
        K_ORI,
        K_LUI,
        K_LW,
        K_SW,
        K_BEQ,
        K_J,
        K_JAL,
        K_JR,
        K_ILL
    } kind_e;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_write;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    // Select encodings
    localparam logic [1:0] PC_ALU   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JUMP  = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MDR   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] ALU_LUI  = 2'd3;

    // Opcodes / functs
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Fetch counter only needs to reach FETCH_CYC-1 <= 3.
    localparam int           FC_W      = 2;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FETCH_CYC - 1);

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [FC_W-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    kind_e              kind;
    ctl_t               ctl;
    logic               fetch_last;

    // -------------------------------------------------------------------------
    // Instruction decode from the IR fields
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the case statements leaves it unassigned
        // and no latch is inferred.
        kind = K_ILL;
        unique case (bus.op)
            OP_RTYPE: begin
                if (bus.funct == FN_ADDU)      kind = K_ADDU;
                else if (bus.funct == FN_SUBU) kind = K_SUBU;
                else if (bus.funct == FN_JR)   kind = K_JR;
                else                           kind = K_ILL;
            end
            OP_ORI:  kind = K_ORI;
            OP_LUI:  kind = K_LUI;
            OP_LW:   kind = K_LW;
            OP_SW:   kind = K_SW;
            OP_BEQ:  kind = K_BEQ;
            OP_J:    kind = K_J;
            OP_JAL:  kind = K_JAL;
            default: kind = K_ILL;
        endcase
    end

    assign fetch_last = (fetch_cnt_q == FC_LAST);

    // -------------------------------------------------------------------------
    // Next state and per-state outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ctl         = '0;
        state_d     = state_q;
        fetch_cnt_d = '0;

        unique case (state_q)
            S_FETCH: begin
                if (fetch_last) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_ALU;
                    state_d      = S_DECODE;
                end else begin
                    // Waiting on memory latency; counter clears on exit.
                    fetch_cnt_d  = fetch_cnt_q + FC_W'(1);
                end
            end

            S_DECODE: begin
                unique case (kind)
                    K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ: begin
                        state_d = S_EXE;
                    end
                    K_J: begin
                        ctl.pc_write   = 1'b1;
                        ctl.pc_src     = PC_JUMP;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    K_JAL: begin
                        // The PC register already holds PC+4, which is the
                        // link value written to $31 in this same cycle.
                        ctl.pc_write   = 1'b1;
                        ctl.pc_src     = PC_JUMP;
                        ctl.reg_write  = 1'b1;
                        ctl.reg_dst    = RD_RA;
                        ctl.wd_src     = WD_PC;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    K_JR: begin
                        ctl.pc_write   = 1'b1;
                        ctl.pc_src     = PC_RS;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    default: begin
                        // Undecodable: drop it without touching any state.
                        ctl.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end

            S_EXE: begin
                unique case (kind)
                    K_ADDU: begin
                        ctl.alu_op  = ALU_ADD;
                        ctl.alu_src = 1'b0;
                        state_d     = S_WB;
                    end
                    K_SUBU: begin
                        ctl.alu_op  = ALU_SUB;
                        ctl.alu_src = 1'b0;
                        state_d     = S_WB;
                    end
                    K_ORI: begin
                        ctl.alu_op  = ALU_OR;
                        ctl.alu_src = 1'b1;
                        ctl.ext_op  = 1'b0;
                        state_d     = S_WB;
                    end
                    K_LUI: begin
                        ctl.alu_op  = ALU_LUI;
                        ctl.alu_src = 1'b1;
                        state_d     = S_WB;
                    end
                    K_LW, K_SW: begin
                        ctl.alu_op  = ALU_ADD;
                        ctl.alu_src = 1'b1;
                        ctl.ext_op  = 1'b1;
                        state_d     = S_MEM;
                    end
                    K_BEQ: begin
                        // ALU compares rs-rt while the branch target (PC+4 +
                        // offset, sign-extended) is selected for the PC.
                        ctl.alu_op     = ALU_SUB;
                        ctl.alu_src    = 1'b0;
                        ctl.ext_op     = 1'b1;
                        ctl.pc_src     = PC_BR;
                        ctl.pc_write   = bus.zero;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                unique case (kind)
                    K_SW: begin
                        ctl.mem_write  = 1'b1;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    K_LW: begin
                        // MDR captures every cycle; nothing to enable here.
                        state_d = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
                unique case (kind)
                    K_ADDU, K_SUBU: begin
                        ctl.reg_dst = RD_RD;
                        ctl.wd_src  = WD_ALU;
                    end
                    K_LW: begin
                        ctl.reg_dst = RD_RT;
                        ctl.wd_src  = WD_MDR;
                    end
                    default: begin
                        ctl.reg_dst = RD_RT;
                        ctl.wd_src  = WD_ALU;
                    end
                endcase
            end

            // Unused encodings 5..7 recover to FETCH on the next edge.
            default: state_d = S_FETCH;
        endcase

        // Reset aborts whatever is in flight: no enables, all selects at 0.
        if (reset) begin
            ctl = '0;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (ctl.instr_done) begin
            retired_d = retired_q + CNT_W'(1);   // wraps, no saturation
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset here is synchronous -- it is only sampled on the clock
        // edge, so it lives inside the clocked block with no sensitivity to
        // reset itself.
        if (reset) begin
            state_q     <= S_FETCH;
            fetch_cnt_q <= '0;
            retired_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            retired_q   <= retired_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ir_write   = ctl.ir_write;
    assign bus.pc_write   = ctl.pc_write;
    assign bus.pc_src     = ctl.pc_src;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.wd_src     = ctl.wd_src;
    assign bus.alu_src    = ctl.alu_src;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.ext_op     = ctl.ext_op;
    assign bus.mem_write  = ctl.mem_write;
    assign bus.instr_done = ctl.instr_done;
    assign bus.illegal    = ctl.illegal;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Main DUT: CNT_W=4, FETCH_CYC=1. A table of instructions is applied one by
// one; for each, a cycle-indexed reference model pushes the expected output
// bundle of every cycle into a queue, and a negedge monitor pops and compares.
// Hand-written sequences cover reset, reset during S_MEM, counter wrap, and a
// second DUT with FETCH_CYC=3.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(4)) bus ();
    mc_ctrl_if #(.CNT_W(8)) bus3 ();

    mc_ctrl #(.CNT_W(4), .FETCH_CYC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mc_ctrl #(.CNT_W(8), .FETCH_CYC(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_write;
        logic       instr_done;
        logic       illegal;
        logic [3:0] retired;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         exp_cycles;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];
    logic [3:0] model_ret;
    string      cur_name = "idle";
    int         cyc_cnt = 0;
    int         last_len = 0;
    vec_t       vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t sample();
        exp_t s;
        s.state      = bus.state;
        s.ir_write   = bus.ir_write;
        s.pc_write   = bus.pc_write;
        s.pc_src     = bus.pc_src;
        s.reg_write  = bus.reg_write;
        s.reg_dst    = bus.reg_dst;
        s.wd_src     = bus.wd_src;
        s.alu_src    = bus.alu_src;
        s.alu_op     = bus.alu_op;
        s.ext_op     = bus.ext_op;
        s.mem_write  = bus.mem_write;
        s.instr_done = bus.instr_done;
        s.illegal    = bus.illegal;
        s.retired    = bus.retired;
        return s;
    endfunction

    // Reference model: list the expected bundle for each cycle of one
    // instruction, FETCH_CYC=1.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        exp_t  e;
        string k;
        if (op == 6'h00 && funct == 6'h21)      k = "addu";
        else if (op == 6'h00 && funct == 6'h23) k = "subu";
        else if (op == 6'h00 && funct == 6'h08) k = "jr";
        else if (op == 6'h0d)                   k = "ori";
        else if (op == 6'h0f)                   k = "lui";
        else if (op == 6'h23)                   k = "lw";
        else if (op == 6'h2b)                   k = "sw";
        else if (op == 6'h04)                   k = "beq";
        else if (op == 6'h02)                   k = "j";
        else if (op == 6'h03)                   k = "jal";
        else                                    k = "ill";

        // cycle 1: fetch
        e = '0; e.state = 3'd0; e.ir_write = 1'b1; e.pc_write = 1'b1; e.retired = model_ret;
        exp_q.push_back(e);

        // cycle 2: decode
        e = '0; e.state = 3'd1; e.retired = model_ret;
        if (k == "j" || k == "jal" || k == "jr") begin
            e.pc_write   = 1'b1;
            e.pc_src     = (k == "jr") ? 2'd3 : 2'd2;
            e.instr_done = 1'b1;
            if (k == "jal") begin
                e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wd_src = 2'd2;
            end
            exp_q.push_back(e);
            model_ret++;
            return;
        end
        if (k == "ill") begin
            e.illegal = 1'b1;
            exp_q.push_back(e);
            return;
        end
        exp_q.push_back(e);

        // cycle 3: execute
        e = '0; e.state = 3'd2; e.retired = model_ret;
        case (k)
            "subu": e.alu_op = 2'd1;
            "ori":  begin e.alu_op = 2'd2; e.alu_src = 1'b1; end
            "lui":  begin e.alu_op = 2'd3; e.alu_src = 1'b1; end
            "lw", "sw": begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
            "beq":  begin
                e.alu_op = 2'd1; e.ext_op = 1'b1; e.pc_src = 2'd1;
                e.pc_write = zero; e.instr_done = 1'b1;
            end
            default: ;
        endcase
        exp_q.push_back(e);
        if (k == "beq") begin
            model_ret++;
            return;
        end

        // cycle 4: memory (lw/sw only)
        if (k == "lw" || k == "sw") begin
            e = '0; e.state = 3'd3; e.retired = model_ret;
            if (k == "sw") begin
                e.mem_write = 1'b1; e.instr_done = 1'b1;
                exp_q.push_back(e);
                model_ret++;
                return;
            end
            exp_q.push_back(e);
        end

        // last cycle: write back
        e = '0; e.state = 3'd4; e.retired = model_ret;
        e.reg_write = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (k == "addu" || k == "subu") ? 2'd1 : 2'd0;
        e.wd_src  = (k == "lw") ? 2'd1 : 2'd0;
        exp_q.push_back(e);
        model_ret++;
    endtask

    // Scoreboard monitor: compare mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e_exp;
        exp_t e_act;
        if (exp_q.size() != 0) begin
            e_exp = exp_q.pop_front();
            e_act = sample();
            check({"cycle ", cur_name}, 32'(e_act), 32'(e_exp));
        end
        cyc_cnt++;
        if (bus.instr_done || bus.illegal) last_len = cyc_cnt;
    end

    // Start an instruction at posedge+1 of a FETCH cycle and wait until the
    // model's cycles are all consumed.
    task automatic run_instr(input vec_t v);
        cur_name  = v.name;
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        cyc_cnt   = 0;
        last_len  = 0;
        push_instr(v.op, v.funct, v.zero);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            check({"drain ", v.name}, exp_q.size(), 0);
            exp_q.delete();
        end
        check({"len ", v.name}, last_len, v.exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] st3 [6];
        logic       irw3[6];
        logic       dn3 [6];

        vecs[0]  = '{"addu",   6'h00, 6'h21, 1'b0, 4};
        vecs[1]  = '{"lw",     6'h23, 6'h00, 1'b0, 5};
        vecs[2]  = '{"sw",     6'h2b, 6'h00, 1'b0, 4};
        vecs[3]  = '{"beq_z1", 6'h04, 6'h00, 1'b1, 3};
        vecs[4]  = '{"beq_z0", 6'h04, 6'h00, 1'b0, 3};
        vecs[5]  = '{"jal",    6'h03, 6'h00, 1'b0, 2};
        vecs[6]  = '{"ill_op", 6'h3f, 6'h00, 1'b0, 2};
        vecs[7]  = '{"subu",   6'h00, 6'h23, 1'b0, 4};
        vecs[8]  = '{"ori",    6'h0d, 6'h15, 1'b0, 4};
        vecs[9]  = '{"lui",    6'h0f, 6'h2a, 1'b1, 4};
        vecs[10] = '{"j",      6'h02, 6'h3f, 1'b0, 2};
        vecs[11] = '{"jr",     6'h00, 6'h08, 1'b0, 2};
        vecs[12] = '{"ill_fn", 6'h00, 6'h00, 1'b0, 2};

        st3  = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
        irw3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dn3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset     = 1'b1;
        bus.op    = 6'h00; bus.funct  = 6'h21; bus.zero  = 1'b1;
        bus3.op   = 6'h00; bus3.funct = 6'h00; bus3.zero = 1'b0;
        model_ret = '0;

        // Reset held for two cycles: enables and selects all 0.
        repeat (2) begin
            @(negedge clk);
            check("rst_enables", {bus.ir_write, bus.pc_write, bus.reg_write,
                                  bus.mem_write, bus.instr_done, bus.illegal}, 0);
            check("rst_selects", {bus.pc_src, bus.reg_dst, bus.wd_src,
                                  bus.alu_src, bus.alu_op, bus.ext_op}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_state", bus.state, 0);
        check("rst_retired", bus.retired, 0);

        // Table-driven instruction sequence.
        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i]);
            if (i == 0) check("retired_after_addu", bus.retired, 1);
        end
        check("retired_total", bus.retired, 11);   // 11 legal, 2 illegal

        // Reset asserted during S_MEM of sw aborts the store.
        cur_name  = "sw_abort";
        bus.op    = 6'h2b; bus.funct = 6'h00; bus.zero = 1'b0;
        @(negedge clk); check("abort_fetch",  bus.state, 0);
        @(negedge clk); check("abort_decode", bus.state, 1);
        @(negedge clk); check("abort_exe",    bus.state, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_state", bus.state, 3);
        check("abort_mem_write", bus.mem_write, 0);
        check("abort_done",      bus.instr_done, 0);
        @(negedge clk);
        check("abort_state_after", bus.state, 0);
        check("abort_retired",     bus.retired, 0);
        @(posedge clk); #1;
        reset     = 1'b0;
        model_ret = '0;

        // 16 jumps wrap the 4-bit retired counter back to 0.
        for (int i = 0; i < 16; i++) run_instr(vecs[10]);
        check("retired_wrap", bus.retired, 0);

        // FETCH_CYC=3 instance: addu takes 6 cycles, IR loads on the third.
        bus3.op = 6'h00; bus3.funct = 6'h21;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("f3_state_%0d", i), bus3.state, 32'(st3[i]));
            check($sformatf("f3_irw_%0d", i), bus3.ir_write, 32'(irw3[i]));
            check($sformatf("f3_done_%0d", i), bus3.instr_done, 32'(dn3[i]));
        end
        @(posedge clk); #1;
        check("f3_retired", bus3.retired, 1);
        check("f3_refetch", bus3.state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
